// File: rtl/mux_16to1_rr.sv
// Registered 16-to-1 round-robin merge: gathers valid/ready lanes onto one
// output lane, tagging each word with the channel it came from.
module mux_16to1_rr #(
  parameter int width = 8,
  parameter int snum  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [width-1:0]   i0,
  input  logic [width-1:0]   i1,
  input  logic [width-1:0]   i2,
  input  logic [width-1:0]   i3,
  input  logic [width-1:0]   i4,
  input  logic [width-1:0]   i5,
  input  logic [width-1:0]   i6,
  input  logic [width-1:0]   i7,
  input  logic [width-1:0]   i8,
  input  logic [width-1:0]   i9,
  input  logic [width-1:0]   i10,
  input  logic [width-1:0]   i11,
  input  logic [width-1:0]   i12,
  input  logic [width-1:0]   i13,
  input  logic [width-1:0]   i14,
  input  logic [width-1:0]   i15,
  input  logic [15:0]        vld,
  output logic [15:0]        rdy,
  output logic [width-1:0]   o,
  output logic [snum-1:0]    o_sel,
  output logic               o_vld,
  input  logic               o_rdy
);

  localparam int n = 2 ** snum;

  logic [width-1:0] din [n];
  logic [width-1:0] o_reg;
  logic [snum-1:0]  o_sel_reg;
  logic             o_vld_reg;
  logic [snum-1:0]  ptr_reg;
  logic [snum-1:0]  grant;
  logic [snum-1:0]  idx;
  logic             req;
  logic             ld;
  logic             go;

  assign din[0]  = i0;
  assign din[1]  = i1;
  assign din[2]  = i2;
  assign din[3]  = i3;
  assign din[4]  = i4;
  assign din[5]  = i5;
  assign din[6]  = i6;
  assign din[7]  = i7;
  assign din[8]  = i8;
  assign din[9]  = i9;
  assign din[10] = i10;
  assign din[11] = i11;
  assign din[12] = i12;
  assign din[13] = i13;
  assign din[14] = i14;
  assign din[15] = i15;

  // Scan from the farthest offset back toward ptr so the nearest requester wins.
  always_comb begin
    grant = ptr_reg;
    idx   = ptr_reg;
    for (int off = n - 1; off >= 0; off--) begin
      idx = ptr_reg + snum'(off);
      if (vld[idx]) grant = idx;
    end
  end

  assign req = |vld;
  assign ld  = !o_vld_reg || o_rdy;
  assign go  = ld && req && !rst;

  generate
    for (genvar gi = 0; gi < n; gi++) begin : g_rdy
      assign rdy[gi] = go && (grant == snum'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      o_reg     <= '0;
      o_sel_reg <= '0;
      o_vld_reg <= 1'b0;
      ptr_reg   <= '0;
    end else if (go) begin
      // A new word may overwrite one draining this same cycle.
      o_reg     <= din[grant];
      o_sel_reg <= grant;
      o_vld_reg <= 1'b1;
      ptr_reg   <= grant + 1'b1;
    end else if (o_vld_reg && o_rdy) begin
      o_vld_reg <= 1'b0;
    end
  end

  assign o     = o_reg;
  assign o_sel = o_sel_reg;
  assign o_vld = o_vld_reg;

endmodule

// File: tb/tb_mux_16to1_rr.sv
// Directed bench for mux_16to1_rr: table of per-cycle vectors with
// hand-computed rdy/output expectations plus a reset-mid-stream sequence.
module tb_mux_16to1_rr;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  din [16];
  logic [15:0] vld;
  logic [15:0] rdy;
  logic [7:0]  o;
  logic [3:0]  o_sel;
  logic        o_vld;
  logic        o_rdy;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        r;
    logic [15:0] v;
    logic        ordy;
    int          dch;
    logic [7:0]  dval;
    logic [15:0] erdy;
    logic [7:0]  eo;
    logic [3:0]  esel;
    logic        evld;
  } vec_t;

  vec_t tbl[$];

  mux_16to1_rr #(.width(8), .snum(4)) dut (
    .clk(clk), .rst(rst),
    .i0(din[0]),   .i1(din[1]),   .i2(din[2]),   .i3(din[3]),
    .i4(din[4]),   .i5(din[5]),   .i6(din[6]),   .i7(din[7]),
    .i8(din[8]),   .i9(din[9]),   .i10(din[10]), .i11(din[11]),
    .i12(din[12]), .i13(din[13]), .i14(din[14]), .i15(din[15]),
    .vld(vld), .rdy(rdy), .o(o), .o_sel(o_sel), .o_vld(o_vld), .o_rdy(o_rdy)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic [15:0] v, logic ordy, int dch, logic [7:0] dval,
                              logic [15:0] erdy, logic [7:0] eo, logic [3:0] esel, logic evld);
    vec_t t;
    t.r = r; t.v = v; t.ordy = ordy; t.dch = dch; t.dval = dval;
    t.erdy = erdy; t.eo = eo; t.esel = esel; t.evld = evld;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Default lane data is {k,4'h0}; one lane may be overridden.
  task automatic set_in(input logic r, input logic [15:0] v, input logic ordy,
                        input int dch, input logic [7:0] dval);
    for (int k = 0; k < 16; k++) begin
      logic [3:0] kk;
      kk = 4'(k);
      din[k] = {kk, 4'h0};
    end
    if (dch >= 0) din[dch] = dval;
    rst = r;
    vld = v;
    o_rdy = ordy;
  endtask

  initial begin
    int got;
    set_in(1'b1, 16'hFFFF, 1'b1, -1, 8'h00);

    // reset held two cycles with all lanes requesting
    tbl.push_back(mk(1, 16'hFFFF, 1, -1, 8'h00, 16'h0000, 8'h00, 4'd0, 0));
    tbl.push_back(mk(1, 16'hFFFF, 1, -1, 8'h00, 16'h0000, 8'h00, 4'd0, 0));
    // first grant after release is channel 0
    tbl.push_back(mk(0, 16'h0001, 1, -1, 8'h00, 16'h0001, 8'h00, 4'd0, 1));
    // single lane 5, then drop vld and drain
    tbl.push_back(mk(0, 16'h0020, 1, 5, 8'hA0, 16'h0020, 8'hA0, 4'd5, 1));
    tbl.push_back(mk(0, 16'h0000, 1, -1, 8'h00, 16'h0000, 8'hA0, 4'd5, 0));
    // reset pointer, then 17 cycles of full round robin
    tbl.push_back(mk(1, 16'h0000, 1, -1, 8'h00, 16'h0000, 8'h00, 4'd0, 0));
    for (int j = 0; j < 17; j++) begin
      logic [3:0] c;
      c = 4'(j % 16);
      tbl.push_back(mk(0, 16'hFFFF, 1, -1, 8'h00, 16'(1 << (j % 16)), {c, 4'h0}, c, 1));
    end
    tbl.push_back(mk(0, 16'h0000, 1, -1, 8'h00, 16'h0000, 8'h00, 4'd0, 0));
    // ptr=1 -> ch13 grant leaves ptr=14; then wrap and skip 15,1,2
    tbl.push_back(mk(0, 16'h2000, 1, -1, 8'h00, 16'h2000, 8'hD0, 4'd13, 1));
    tbl.push_back(mk(0, 16'h8006, 1, -1, 8'h00, 16'h8000, 8'hF0, 4'd15, 1));
    tbl.push_back(mk(0, 16'h0006, 1, -1, 8'h00, 16'h0002, 8'h10, 4'd1, 1));
    tbl.push_back(mk(0, 16'h0004, 1, -1, 8'h00, 16'h0004, 8'h20, 4'd2, 1));
    // ptr must now be 3: ch3 beats ch0
    tbl.push_back(mk(0, 16'h0009, 1, -1, 8'h00, 16'h0008, 8'h30, 4'd3, 1));
    tbl.push_back(mk(0, 16'h0001, 1, -1, 8'h00, 16'h0001, 8'h00, 4'd0, 1));
    tbl.push_back(mk(0, 16'h0000, 1, -1, 8'h00, 16'h0000, 8'h00, 4'd0, 0));
    // backpressure: load B0 from ch1 with o_rdy low, hold 3 cycles
    tbl.push_back(mk(0, 16'h0002, 0, 1, 8'hB0, 16'h0002, 8'hB0, 4'd1, 1));
    tbl.push_back(mk(0, 16'h0004, 0, -1, 8'h00, 16'h0000, 8'hB0, 4'd1, 1));
    tbl.push_back(mk(0, 16'h0004, 0, -1, 8'h00, 16'h0000, 8'hB0, 4'd1, 1));
    tbl.push_back(mk(0, 16'h0004, 0, -1, 8'h00, 16'h0000, 8'hB0, 4'd1, 1));
    tbl.push_back(mk(0, 16'h0004, 1, -1, 8'h00, 16'h0004, 8'h20, 4'd2, 1));
    tbl.push_back(mk(0, 16'h0000, 1, -1, 8'h00, 16'h0000, 8'h20, 4'd2, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      set_in(tbl[i].r, tbl[i].v, tbl[i].ordy, tbl[i].dch, tbl[i].dval);
      #1;
      chk($sformatf("v%0d_rdy", i), 32'(rdy), 32'(tbl[i].erdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_o", i), 32'(o), 32'(tbl[i].eo));
      chk($sformatf("v%0d_sel", i), 32'(o_sel), 32'(tbl[i].esel));
      chk($sformatf("v%0d_vld", i), 32'(o_vld), 32'(tbl[i].evld));
      $display("vec %0d: vld=%h rdy=%h o=%h sel=%0d o_vld=%0b", i, vld, rdy, o, o_sel, o_vld);
    end

    // Reset mid-stream: ptr=3, burst grants 3 then 4, stall holding 40
    set_in(0, 16'hFFFF, 1, -1, 8'h00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("burst_o", 32'(o), 32'h40);
    set_in(0, 16'hFFFF, 0, -1, 8'h00);
    #1;
    chk("stall_rdy", 32'(rdy), 32'h0);
    set_in(1, 16'hFFFF, 0, -1, 8'h00);
    #1;
    chk("rst_rdy", 32'(rdy), 32'h0);
    @(posedge clk); #1;
    chk("rst_vld", 32'(o_vld), 32'h0);
    chk("rst_o", 32'(o), 32'h0);
    chk("rst_sel", 32'(o_sel), 32'h0);
    $display("mid-stream reset: o=%h sel=%0d o_vld=%0b", o, o_sel, o_vld);
    set_in(0, 16'hFFFF, 1, -1, 8'h00);
    #1;
    got = 0;
    for (int c = 0; c < 20 && rdy == 16'h0; c++) begin
      @(posedge clk); #1;
      got++;
    end
    chk("post_rst_wait", got, 0);
    chk("post_rst_rdy", 32'(rdy), 32'h0001);
    @(posedge clk); #1;
    chk("post_rst_o", 32'(o), 32'h00);
    chk("post_rst_sel", 32'(o_sel), 32'h0);
    chk("post_rst_rdy2", 32'(rdy), 32'h0002);
    @(posedge clk); #1;
    chk("post_rst_o2", 32'(o), 32'h10);
    $display("after reset: o=%h sel=%0d o_vld=%0b", o, o_sel, o_vld);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
